// File: rtl/fire_sched_pkg.sv
// Shared types and helpers for the fire scheduler.
// Contents: FSM state enum, LFSR feedback taps and step function, idle-code helper.
// No ports; imported by the scheduler top.
package fire_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    DEAD = 2'd3
  } sched_state_t;

  // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci LFSR:
  // feedback is the XOR of bits 0, 2, 3 and 5, entering at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction

  // The idle code on the fire bus is one past the last transition index.
  function automatic int idle_code(input int ntrans);
    return ntrans;
  endfunction

endpackage

// File: rtl/fire_scheduler_if.sv
// Bundle of the scheduler's control inputs and fire-bus outputs.
// master: scheduler side (takes en_vec/run/step/mode_rand/clr, drives fire/fire_valid/deadlock/fired_count).
// slave: model/controller side, the mirror image.
interface fire_scheduler_if #(
  parameter int NTRANS = 8,
  parameter int FW     = $clog2(NTRANS + 1)
) ();

  logic [NTRANS-1:0] en_vec;
  logic              run;
  logic              step;
  logic              mode_rand;
  logic              clr;
  logic [FW-1:0]     fire;
  logic              fire_valid;
  logic              deadlock;
  logic [15:0]       fired_count;

  modport master (
    input  en_vec, run, step, mode_rand, clr,
    output fire, fire_valid, deadlock, fired_count
  );

  modport slave (
    output en_vec, run, step, mode_rand, clr,
    input  fire, fire_valid, deadlock, fired_count
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of en_vec scanning start, start+1, ..., wrapping at N.
// Ports: en_vec (N), start (W, must be < N) -> index (W), found (1). Purely combinational.
// Zero latency; no flow control.
module rr_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] en_vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] index,
  output logic         found
);

  localparam logic [W:0] N_EXT = (W + 1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;
  logic [W:0]     sum;

  // Rotate so that bit 0 of rot corresponds to en_vec[start].
  assign dbl = {en_vec, en_vec} >> start;
  assign rot = dbl[N-1:0];

  always_comb begin
    off   = '0;
    found = 1'b0;
    // Descending scan so the smallest offset is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= N_EXT) sum = sum - N_EXT;
  end

  assign index = sum[W-1:0];

endmodule

// File: rtl/fire_scheduler.sv
// Picks one enabled transition per cycle for the fire bus (round-robin or LFSR start), with run/step control and deadlock detection.
// Ports: clk, reset (async active-low), bus (fire_scheduler_if.master: en_vec/run/step/mode_rand/clr in; fire/fire_valid/deadlock/fired_count out).
// fire is combinational from registered state and en_vec (zero latency); no backpressure, DEAD holds until clr.
module fire_scheduler
  import fire_sched_pkg::*;
#(
  parameter int          NTRANS    = 8,
  parameter int          FW        = $clog2(NTRANS + 1),
  parameter int          DL_LIMIT  = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic              clk,
  input logic              reset,
  fire_scheduler_if.master bus
);

  localparam logic [FW-1:0] IDLE_CODE = FW'(idle_code(NTRANS));
  localparam logic [FW-1:0] LAST_IDX  = FW'(NTRANS - 1);
  localparam logic [FW:0]   NT_EXT    = (FW + 1)'(NTRANS);
  localparam logic [3:0]    DL_LIM    = 4'(DL_LIMIT);

  sched_state_t  state;
  logic [FW-1:0] ptr;
  logic [15:0]   lfsr;
  logic [3:0]    dl_cnt;
  logic          deadlock;
  logic [15:0]   fired_count;

  logic [FW:0]   rnd_a;
  logic [FW:0]   rnd_b;
  logic [FW-1:0] start;
  logic [FW-1:0] pick;
  logic          found;
  logic          active;
  logic          fire_now;
  logic          any_en;

  // Low LFSR bits folded into 0..NTRANS-1; two subtractions cover any FW-bit value.
  always_comb begin
    rnd_a = {1'b0, lfsr[FW-1:0]};
    if (rnd_a >= NT_EXT) rnd_a = rnd_a - NT_EXT;
    rnd_b = rnd_a;
    if (rnd_b >= NT_EXT) rnd_b = rnd_b - NT_EXT;
  end

  assign start = bus.mode_rand ? rnd_b[FW-1:0] : ptr;

  rr_pick #(
    .N (NTRANS),
    .W (FW)
  ) u_pick (
    .en_vec (bus.en_vec),
    .start  (start),
    .index  (pick),
    .found  (found)
  );

  assign any_en   = |bus.en_vec;
  assign active   = (state == RUN) || (state == STEP);
  assign fire_now = active && found;

  assign bus.fire        = fire_now ? pick : IDLE_CODE;
  assign bus.fire_valid  = fire_now;
  assign bus.deadlock    = deadlock;
  assign bus.fired_count = fired_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      lfsr        <= LFSR_SEED;
      dl_cnt      <= '0;
      deadlock    <= 1'b0;
      fired_count <= '0;
    end else begin
      // The LFSR free-runs while scheduling, independent of mode.
      if (active) lfsr <= lfsr_next(lfsr);

      if (fire_now) begin
        ptr <= (pick == LAST_IDX) ? '0 : pick + 1'b1;
        if (fired_count != 16'hFFFF) fired_count <= fired_count + 16'd1;
      end

      case (state)
        IDLE: begin
          if (bus.run)       state <= RUN;
          else if (bus.step) state <= STEP;
        end
        RUN: begin
          if (!any_en) begin
            dl_cnt <= dl_cnt + 4'd1;
            if (dl_cnt + 4'd1 >= DL_LIM) begin
              state    <= DEAD;
              deadlock <= 1'b1;
            end else if (!bus.run) begin
              state <= IDLE;
            end
          end else begin
            dl_cnt <= '0;
            if (!bus.run) state <= IDLE;
          end
        end
        STEP: begin
          if (!any_en) begin
            state    <= DEAD;
            deadlock <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        DEAD: begin
          if (bus.clr) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Clear overrides any same-cycle count or flag update; the state move above still stands.
      if (bus.clr) begin
        deadlock    <= 1'b0;
        dl_cnt      <= '0;
        fired_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fire_scheduler.sv
// Self-checking bench for fire_scheduler: directed scenarios plus randomized enables against a behavioural model.
// Ports: none (top level); instantiates fire_scheduler_if and fire_scheduler with NTRANS=8, DL_LIMIT=3.
// Inputs change 1 time unit after posedge; outputs are sampled 3 units after posedge.
module tb_fire_scheduler;

  localparam int N   = 8;
  localparam int FWB = 4;
  localparam int DL  = 3;

  // Model's own phase labels.
  localparam int M_IDLE = 10;
  localparam int M_RUN  = 11;
  localparam int M_STEP = 12;
  localparam int M_DEAD = 13;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fire_scheduler_if #(.NTRANS(N)) bus ();

  fire_scheduler #(
    .NTRANS    (N),
    .DL_LIMIT  (DL),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int m_phase;
  int m_ptr;
  int m_dl;
  int m_cnt;
  int m_lfsr;
  bit m_dead;

  bit seen [N];
  bit rnd_phase = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_phase = M_IDLE;
    m_ptr   = 0;
    m_dl    = 0;
    m_cnt   = 0;
    m_lfsr  = 16'hACE1;
    m_dead  = 1'b0;
  endtask

  // Expected fire value from the scheduling rules.
  function automatic int model_fire();
    int s;
    if (!(m_phase == M_RUN || m_phase == M_STEP)) return N;
    if (bus.mode_rand) s = (m_lfsr % (1 << FWB)) % N;
    else               s = m_ptr;
    for (int k = 0; k < N; k++) begin
      if (bus.en_vec[(s + k) % N]) return (s + k) % N;
    end
    return N;
  endfunction

  task automatic model_edge(input int f);
    bit any;
    bit act;
    int fb;
    any = (bus.en_vec != '0);
    act = (m_phase == M_RUN) || (m_phase == M_STEP);
    if (f < N) begin
      m_ptr = (f + 1) % N;
      if (m_cnt < 65535) m_cnt++;
    end
    if (act) begin
      fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
      m_lfsr = (m_lfsr >> 1) | (fb << 15);
    end
    case (m_phase)
      M_IDLE: begin
        if (bus.run)       m_phase = M_RUN;
        else if (bus.step) m_phase = M_STEP;
      end
      M_RUN: begin
        if (!any) begin
          m_dl++;
          if (m_dl >= DL) begin
            m_phase = M_DEAD;
            m_dead  = 1'b1;
          end else if (!bus.run) m_phase = M_IDLE;
        end else begin
          m_dl = 0;
          if (!bus.run) m_phase = M_IDLE;
        end
      end
      M_STEP: begin
        if (!any) begin
          m_phase = M_DEAD;
          m_dead  = 1'b1;
        end else m_phase = M_IDLE;
      end
      default: if (bus.clr) m_phase = M_IDLE;
    endcase
    if (bus.clr) begin
      m_dead = 1'b0;
      m_dl   = 0;
      m_cnt  = 0;
    end
  endtask

  // One clock: entered at posedge+1, checks mid-cycle, returns at next posedge+1.
  task automatic tick(input string tag, input int exp_fire);
    int f;
    #2;
    f = model_fire();
    check({tag, ".fire"}, 32'(bus.fire), f);
    check({tag, ".vld"}, 32'(bus.fire_valid), 32'(f < N));
    check({tag, ".dead"}, 32'(bus.deadlock), 32'(m_dead));
    check({tag, ".cnt"}, 32'(bus.fired_count), m_cnt);
    if (exp_fire >= 0) check({tag, ".exp"}, 32'(bus.fire), exp_fire);
    if (bus.fire_valid === 1'b1 && bus.fire < N) begin
      check({tag, ".inv"}, 32'(bus.en_vec[bus.fire]), 1);
      if (rnd_phase) seen[bus.fire] = 1'b1;
    end
    @(posedge clk);
    model_edge(f);
    #1;
  endtask

  initial begin
    int r;
    logic [N-1:0] prev_en;

    reset         = 1'b0;
    bus.en_vec    = 8'hFF;
    bus.run       = 1'b0;
    bus.step      = 1'b0;
    bus.mode_rand = 1'b0;
    bus.clr       = 1'b0;
    model_reset();

    // Reset state
    #1;
    check("rst.fire", 32'(bus.fire), N);
    check("rst.vld", 32'(bus.fire_valid), 0);
    check("rst.cnt", 32'(bus.fired_count), 0);
    check("rst.dead", 32'(bus.deadlock), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick("idle0", N);
    tick("idle1", N);

    // Round-robin with everything enabled
    bus.run = 1'b1;
    tick("rr_go", N);
    for (int i = 0; i < 10; i++) tick("rr", i % N);
    check("rr_cnt", 32'(bus.fired_count), 10);
    bus.run = 1'b0;
    tick("rr_stop", 2);

    // Wrap-around from ptr=3 over en 0010_0100
    bus.en_vec = 8'b0010_0100;
    bus.run    = 1'b1;
    tick("wr_go", N);
    tick("wr_a", 5);
    tick("wr_b", 2);
    bus.run = 1'b0;
    tick("wr_stop", 5);

    // Single step, then run+step together
    bus.en_vec = 8'h01;
    bus.step   = 1'b1;
    tick("st_go", N);
    bus.step = 1'b0;
    tick("st_one", 0);
    tick("st_after", N);
    bus.run  = 1'b1;
    bus.step = 1'b1;
    tick("rs_go", N);
    tick("rs_run", 0);
    bus.step = 1'b0;
    bus.run  = 1'b0;
    tick("rs_stop", 0);

    // Deadlock in RUN after DL_LIMIT empty cycles
    bus.en_vec = '0;
    bus.run    = 1'b1;
    tick("dl_go", N);
    tick("dl1", N);
    tick("dl2", N);
    check("dl_pre", 32'(bus.deadlock), 0);
    tick("dl3", N);
    check("dl_set", 32'(bus.deadlock), 1);
    bus.en_vec = 8'hFF;
    tick("dead_hold", N);
    bus.clr = 1'b1;
    tick("dead_clr", N);
    bus.clr = 1'b0;
    bus.run = 1'b0;
    check("clr_dead", 32'(bus.deadlock), 0);
    check("clr_cnt", 32'(bus.fired_count), 0);
    tick("clr_idle", N);

    // Step with nothing enabled deadlocks immediately
    bus.en_vec = '0;
    bus.step   = 1'b1;
    tick("sd_go", N);
    bus.step = 1'b0;
    tick("sd_step", N);
    check("sd_set", 32'(bus.deadlock), 1);
    bus.clr = 1'b1;
    tick("sd_clr", N);
    bus.clr = 1'b0;

    // Clear wins over a same-cycle count increment
    bus.en_vec = 8'hFF;
    bus.run    = 1'b1;
    tick("ci_go", N);
    tick("ci_a", -1);
    bus.clr = 1'b1;
    tick("ci_b", -1);
    bus.clr = 1'b0;
    check("ci_cnt", 32'(bus.fired_count), 0);

    // Randomized enables, mostly LFSR mode
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
    rnd_phase = 1'b1;
    prev_en   = 8'hFF;
    for (int c = 0; c < 1000; c++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0 && prev_en != '0) bus.en_vec = '0;
      else if (r < 5)              bus.en_vec = N'(1) << $urandom_range(0, N - 1);
      else                         bus.en_vec = N'($urandom_range(1, 255));
      prev_en       = bus.en_vec;
      bus.mode_rand = ($urandom_range(0, 7) != 0);
      tick("rnd", -1);
    end
    rnd_phase = 1'b0;
    for (int i = 0; i < N; i++) check($sformatf("seen%0d", i), 32'(seen[i]), 1);

    // Reset asserted mid-cycle while firing
    bus.en_vec    = 8'hFF;
    bus.mode_rand = 1'b0;
    bus.run       = 1'b1;
    tick("pre_rst", -1);
    #2;
    check("pre_rst.vld", 32'(bus.fire_valid), 1);
    reset = 1'b0;
    #1;
    check("mid_rst.fire", 32'(bus.fire), N);
    check("mid_rst.vld", 32'(bus.fire_valid), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick("post_rst", N);
    tick("post_run", 0);
    tick("post_run2", 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/fire_scheduler.md
Name: fire_scheduler

Overview:
- Drives the `fire` transition-select bus of a synchronous circuit model.
- Each cycle it picks exactly one enabled transition (input or stateful gate) to fire, or the idle code.
- Replaces the unconstrained formal `fire` input when the model runs in simulation, with round-robin or pseudo-random selection, run/step control and deadlock detection.
- Index order matches the model: inputs first (0..NIN-1), then stateful gates.

Parameters:
- NTRANS, 8, number of transitions (inputs + stateful gates); must be >= 2.
- FW, $clog2(NTRANS+1), width of `fire`; value NTRANS is the idle code.
- DL_LIMIT, 1, consecutive zero-enable RUN cycles before `deadlock` asserts; range 1..15.
- LFSR_SEED, 16'hACE1, reset value of the random-mode LFSR; must be non-zero.

Ports:
- clk  in  1  Clock; all state updates on posedge.
- reset  in  1  Asynchronous, active-low reset.
- en_vec  in  NTRANS  Bit i = transition i enabled (signal ^ signal_precap). Changes only after posedge.
- run  in  1  Level; schedule every cycle while high.
- step  in  1  Single-cycle pulse; fire one transition from IDLE.
- mode_rand  in  1  0 = round-robin start point, 1 = LFSR start point. Sampled each cycle.
- clr  in  1  Synchronous clear of `deadlock` and `fired_count`.
- fire  out  FW  Selected transition index, or NTRANS when none.
- fire_valid  out  1  High iff fire < NTRANS.
- deadlock  out  1  Sticky deadlock flag.
- fired_count  out  16  Saturating count of fired transitions.

Behaviour:
- Reset (reset low, immediate): state = IDLE, ptr = 0, lfsr = LFSR_SEED, dl_cnt = 0, deadlock = 0, fired_count = 0, fire = NTRANS, fire_valid = 0.
- `fire` is combinational from registered state/ptr/lfsr and `en_vec`. It is stable for the whole cycle because its inputs change only at posedge. Zero-cycle latency from enable to selection.
- Selection uses start index s:
  - Round-robin mode: s = ptr.
  - Random mode: s = lfsr[FW-1:0] reduced mod NTRANS by at most two conditional subtractions.
  - Pick = first set bit of en_vec scanning s, s+1, …, NTRANS-1, 0, …, s-1.
- `fire` presents the pick only in RUN, or in STEP with any bit of en_vec set; otherwise it presents NTRANS.
- After a valid fire of index k: ptr <= (k == NTRANS-1) ? 0 : k+1; fired_count += 1, saturating at 16'hFFFF.
- The LFSR (x^16+x^14+x^13+x^11+1, Fibonacci) advances every cycle in RUN or STEP, whatever the mode.
- FSM:
  - IDLE: run -> RUN; else step -> STEP; fire = NTRANS.
  - RUN: !run -> IDLE. en_vec == 0 increments dl_cnt; reaching DL_LIMIT -> DEAD with deadlock <= 1. Any enable clears dl_cnt.
  - STEP: lasts one cycle -> IDLE. en_vec == 0 -> DEAD with deadlock <= 1 (DL_LIMIT ignored).
  - DEAD: fire = NTRANS; leave only on clr (-> IDLE) or reset.
- Priority and boundaries:
  - run and step both high in IDLE: run wins, step ignored.
  - step while in RUN/STEP/DEAD: ignored.
  - clr: clears deadlock, dl_cnt and fired_count. It wins over a same-cycle count increment; the FSM transition still happens.
  - Reset mid-operation: fire returns to NTRANS in the same cycle, with no glitch to another index.
  - en_vec all ones in RR mode: indices fire in order 0,1,…,NTRANS-1,0 (strict fairness).
  - Single enabled bit: that bit is always picked, whatever s is.
- Invariant for the bench: fire_valid -> en_vec[fire] == 1.

Decomposition:
- Package fire_sched_pkg: FSM state enum {IDLE, RUN, STEP, DEAD}, LFSR tap constant, idle-code helper function.
- Sub-module rr_pick: parameterised rotating priority encoder (en_vec, start) -> (index, found); purely combinational, instantiated once.

Test Plan:
- Reset with en_vec=8'hFF -> fire=8, fire_valid=0, fired_count=0; after release with run=0, fire stays 8.
- run=1, mode_rand=0, en_vec=8'hFF for 10 cycles -> fire = 0,1,…,7,0,1; fired_count=10.
- run=1, RR mode, en_vec=8'b0010_0100, ptr=3 -> fire=5, then ptr=6 -> fire=2 (wrap-around).
- IDLE, step pulse with en_vec=8'h01 -> exactly one cycle fire=0, then fire=8; run and step together -> RUN.
- run=1, DL_LIMIT=3, en_vec=0 for 3 cycles -> deadlock=1 at cycle 3, fire=8 afterwards; clr -> deadlock=0, IDLE.
- mode_rand=1 for 1000 cycles, random en_vec -> en_vec[fire] always 1 when fire_valid; every enabled index eventually fires; reset asserted mid-run -> fire=8 immediately.
